// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core and its data-memory bus bridge:
// bus width defaults, bridge FSM encoding and a small address helper.
package mips_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

  function automatic logic is_word_aligned(input logic [1:0] byte_lsb);
    return byte_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Loadable up-counter that measures cycles spent waiting for a bus acknowledge.
// tc flags the last permitted wait cycle; the count parks there until reloaded.
module bus_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(TIMEOUT - 1));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Converts the datapath's memread/memwrite access into one req/ack bus transaction,
// stalling the core until the slave answers or the wait times out.
module dmem_bus_bridge
  import mips_pkg::*;
#(
  parameter int AW      = BUS_AW,
  parameter int DW      = BUS_DW,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          misalign,
  output logic          timeout_err
);

  bridge_state_e    state, state_nxt;
  logic             access, aligned;
  logic             start, ack_hit, expire, busy;
  logic [DW-1:0]    cap_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_tc;

  assign access  = memread | memwrite;
  assign aligned = is_word_aligned(addr[1:0]);
  assign busy    = (state == ST_BUSY);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .en    (busy),
    .count (wait_cnt),
    .tc    (wait_tc)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ack_hit   = 1'b0;
    expire    = 1'b0;
    stall     = 1'b0;
    rdata     = '0;
    unique case (state)
      ST_IDLE: begin
        // Gating with reset keeps the core free while the bridge is held in reset.
        if (access && aligned && !reset) begin
          start     = 1'b1;
          stall     = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_tc) begin
          expire    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        rdata     = cap_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the bus-facing and capture registers are reset too, so an abandoned request never leaks stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      cap_q       <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      misalign <= (state == ST_IDLE) && access && !aligned;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= memwrite;
        bus_addr  <= {addr[AW-1:2], 2'b00};
        bus_wdata <= wdata;
      end
      if (ack_hit || expire) begin
        bus_req <= 1'b0;
      end
      if (ack_hit) begin
        cap_q <= bus_we ? '0 : bus_rdata;
      end
      if (expire) begin
        cap_q       <= '0;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
